// File: rtl/bpu_pkg.sv
// Shared branch-unit types: next-PC op encodings, 2-bit counter states and
// the saturating counter update used by the history table.
package bpu_pkg;

   typedef enum logic [1:0] {
      NPC_SEQ  = 2'b00,
      NPC_BR   = 2'b01,
      NPC_JAL  = 2'b10,
      NPC_JALR = 2'b11
   } npc_op_e;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic {
      S_IDLE,
      S_HOLD
   } hold_state_e;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      if (taken) return (cnt == ST) ? ST : cnt + 2'd1;
      return (cnt == SNT) ? SNT : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/branch_flush_ctrl_if.sv
// Pipeline-side bundle of the branch/flush controller: ID and EX inputs,
// redirect and flush outputs, and the statistics counters.
interface branch_flush_ctrl_if #(
   parameter int PC_W   = 32,
   parameter int STAT_W = 32
);
   logic              pc_stall;
   logic              id_valid;
   logic              id_is_branch;
   logic [PC_W-1:0]   id_pc;
   logic [PC_W-1:0]   id_target;
   logic              id_pred_taken;
   logic              ex_valid;
   logic [1:0]        ex_npc_op;
   logic              ex_alu_f;
   logic              ex_pred_taken;
   logic [PC_W-1:0]   ex_pc;
   logic [PC_W-1:0]   ex_target;
   logic              pc_sel;
   logic [PC_W-1:0]   redirect_pc;
   logic              flush_if_id;
   logic              flush_id_ex;
   logic [STAT_W-1:0] branch_cnt;
   logic [STAT_W-1:0] mispred_cnt;

   modport master (
      output pc_stall, id_valid, id_is_branch, id_pc, id_target,
             ex_valid, ex_npc_op, ex_alu_f, ex_pred_taken, ex_pc, ex_target,
      input  id_pred_taken, pc_sel, redirect_pc, flush_if_id, flush_id_ex,
             branch_cnt, mispred_cnt
   );

   modport slave (
      input  pc_stall, id_valid, id_is_branch, id_pc, id_target,
             ex_valid, ex_npc_op, ex_alu_f, ex_pred_taken, ex_pc, ex_target,
      output id_pred_taken, pc_sel, redirect_pc, flush_if_id, flush_id_ex,
             branch_cnt, mispred_cnt
   );
endinterface

// File: rtl/bht_2bit.sv
// Bimodal history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous write port.
module bht_2bit
   import bpu_pkg::*;
#(
   parameter int         DEPTH    = 16,
   parameter logic [1:0] CNT_INIT = WNT,
   localparam int        IDX_W    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [1:0]       rd_cnt_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   logic [1:0] cnt_q [DEPTH];

   // NOTE: the whole array is reset, not just a valid bit, so predictions right after reset are deterministic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
      end else if (wr_en_i) begin
         cnt_q[wr_idx_i] <= sat_update(cnt_q[wr_idx_i], wr_taken_i);
      end
   end

   // A same-cycle write to the read entry is only visible from the next cycle.
   assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_flush_ctrl.sv
// Branch resolution, ID-stage prediction and next-PC/flush control, with a
// pending-redirect hold across fetch stalls and branch statistics.
module branch_flush_ctrl
   import bpu_pkg::*;
#(
   parameter int         PC_W      = 32,
   parameter int         BHT_DEPTH = 16,
   parameter int         PREDICT   = 1,
   parameter logic [1:0] CNT_INIT  = WNT,
   parameter int         STAT_W    = 32
) (
   input logic           clk,
   input logic           rst_n,
   branch_flush_ctrl_if.slave bus
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   npc_op_e           ex_op;
   logic              ex_is_br, ex_mispred, ex_redir, id_pred, redir_live, bht_wr_en, pending;
   logic [PC_W-1:0]   ex_tgt_sel, redir_pc_live;
   hold_state_e       state_q, state_d;
   logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
   logic              pend_flush_q, pend_flush_d;
   logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

   assign ex_op   = npc_op_e'(bus.ex_npc_op);
   assign pending = (state_q == S_HOLD);

   // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
   always_comb begin
      ex_is_br      = bus.ex_valid && (ex_op == NPC_BR);
      ex_mispred    = ex_is_br && (bus.ex_alu_f != bus.ex_pred_taken);
      ex_redir      = ex_mispred || (bus.ex_valid && (ex_op == NPC_JAL || ex_op == NPC_JALR));
      ex_tgt_sel    = (ex_is_br && !bus.ex_alu_f) ? bus.ex_pc + PC_W'(4) : bus.ex_target;
      redir_live    = ex_redir || id_pred;
      redir_pc_live = ex_redir ? ex_tgt_sel : bus.id_target;
      bht_wr_en     = ex_is_br && !pending;
      branch_cnt_d  = branch_cnt_q + STAT_W'(bht_wr_en);
      mispred_cnt_d = mispred_cnt_q + STAT_W'(ex_mispred && !pending);
   end

   generate
      if (PREDICT != 0) begin : g_bht
         logic [1:0] rd_cnt;

         bht_2bit #(
            .DEPTH    (BHT_DEPTH),
            .CNT_INIT (CNT_INIT)
         ) u_bht (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_idx_i   (bus.id_pc[IDX_W+1:2]),
            .rd_cnt_o   (rd_cnt),
            .wr_en_i    (bht_wr_en),
            .wr_idx_i   (bus.ex_pc[IDX_W+1:2]),
            .wr_taken_i (bus.ex_alu_f)
         );

         assign id_pred = bus.id_valid && bus.id_is_branch && rd_cnt[1];
      end else begin : g_static
         assign id_pred = 1'b0;
      end
   endgenerate

   // NOTE: state registers use non-blocking '<=' so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pend_pc_q     <= '0;
         pend_flush_q  <= 1'b0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         pend_pc_q     <= pend_pc_d;
         pend_flush_q  <= pend_flush_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pend_pc_d    = pend_pc_q;
      pend_flush_d = pend_flush_q;
      case (state_q)
         S_IDLE: begin
            if (redir_live && bus.pc_stall) begin
               state_d      = S_HOLD;
               pend_pc_d    = redir_pc_live;
               pend_flush_d = ex_redir;
            end
         end
         S_HOLD: begin
            if (!bus.pc_stall) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is asserted, independent of any clock.
   always_comb begin
      bus.pc_sel      = 1'b0;
      bus.redirect_pc = '0;
      bus.flush_if_id = 1'b0;
      bus.flush_id_ex = 1'b0;
      if (!rst_n) begin
         bus.pc_sel = 1'b0;
      end else if (pending) begin
         bus.pc_sel      = 1'b1;
         bus.redirect_pc = pend_pc_q;
         bus.flush_if_id = 1'b1;
         bus.flush_id_ex = pend_flush_q;
      end else if (redir_live) begin
         bus.pc_sel      = 1'b1;
         bus.redirect_pc = redir_pc_live;
         bus.flush_if_id = 1'b1;
         bus.flush_id_ex = ex_redir;
      end
   end

   assign bus.id_pred_taken = rst_n && id_pred;
   assign bus.branch_cnt    = branch_cnt_q;
   assign bus.mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Scoreboard bench: a static-predict and a bimodal instance see the same
// stimulus; a reference model per mode queues expected outputs each cycle.
`timescale 1ns/1ps
module tb_branch_flush_ctrl;
   import bpu_pkg::*;

   localparam int PC_W   = 32;
   localparam int STAT_W = 32;
   localparam int DEPTH  = 16;

   typedef struct packed {
      logic        stall;
      logic        id_valid;
      logic        id_br;
      logic [31:0] id_pc;
      logic [31:0] id_tgt;
      logic        ex_valid;
      logic [1:0]  op;
      logic        alu_f;
      logic        ex_pred;
      logic [31:0] ex_pc;
      logic [31:0] ex_tgt;
   } stim_t;

   typedef struct packed {
      logic        pred;
      logic        sel;
      logic [31:0] rpc;
      logic        ifid;
      logic        idex;
      logic [31:0] br;
      logic [31:0] mp;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   branch_flush_ctrl_if #(.PC_W(PC_W), .STAT_W(STAT_W)) bus_s ();
   branch_flush_ctrl_if #(.PC_W(PC_W), .STAT_W(STAT_W)) bus_b ();

   branch_flush_ctrl #(
      .PC_W(PC_W), .BHT_DEPTH(DEPTH), .PREDICT(0), .CNT_INIT(WNT), .STAT_W(STAT_W)
   ) u_dut_static (.clk(clk), .rst_n(rst_n), .bus(bus_s));

   branch_flush_ctrl #(
      .PC_W(PC_W), .BHT_DEPTH(DEPTH), .PREDICT(1), .CNT_INIT(WNT), .STAT_W(STAT_W)
   ) u_dut_bimodal (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   exp_t        sb_q[$];
   logic [1:0]  m_bht [2][DEPTH];
   logic        m_pend_v [2];
   logic [31:0] m_pend_pc [2];
   logic        m_pend_fl [2];
   logic [31:0] m_br [2];
   logic [31:0] m_mp [2];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input stim_t s);
      bus_s.pc_stall      = s.stall;    bus_b.pc_stall      = s.stall;
      bus_s.id_valid      = s.id_valid; bus_b.id_valid      = s.id_valid;
      bus_s.id_is_branch  = s.id_br;    bus_b.id_is_branch  = s.id_br;
      bus_s.id_pc         = s.id_pc;    bus_b.id_pc         = s.id_pc;
      bus_s.id_target     = s.id_tgt;   bus_b.id_target     = s.id_tgt;
      bus_s.ex_valid      = s.ex_valid; bus_b.ex_valid      = s.ex_valid;
      bus_s.ex_npc_op     = s.op;       bus_b.ex_npc_op     = s.op;
      bus_s.ex_alu_f      = s.alu_f;    bus_b.ex_alu_f      = s.alu_f;
      bus_s.ex_pred_taken = s.ex_pred;  bus_b.ex_pred_taken = s.ex_pred;
      bus_s.ex_pc         = s.ex_pc;    bus_b.ex_pc         = s.ex_pc;
      bus_s.ex_target     = s.ex_tgt;   bus_b.ex_target     = s.ex_tgt;
   endtask

   function automatic exp_t observe(input int m);
      exp_t o;
      if (m == 0) o = '{bus_s.id_pred_taken, bus_s.pc_sel, bus_s.redirect_pc, bus_s.flush_if_id,
                        bus_s.flush_id_ex, bus_s.branch_cnt, bus_s.mispred_cnt};
      else        o = '{bus_b.id_pred_taken, bus_b.pc_sel, bus_b.redirect_pc, bus_b.flush_if_id,
                        bus_b.flush_id_ex, bus_b.branch_cnt, bus_b.mispred_cnt};
      return o;
   endfunction

   function automatic stim_t ex_stim(input logic [1:0] op, input logic alu_f, input logic pred,
                                     input logic [31:0] pc, input logic [31:0] tgt);
      stim_t s = '0;
      s.ex_valid = 1'b1; s.op = op; s.alu_f = alu_f; s.ex_pred = pred; s.ex_pc = pc; s.ex_tgt = tgt;
      return s;
   endfunction

   function automatic stim_t with_id(input stim_t s_in, input logic [31:0] pc, input logic [31:0] tgt);
      stim_t s = s_in;
      s.id_valid = 1'b1; s.id_br = 1'b1; s.id_pc = pc; s.id_tgt = tgt;
      return s;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < DEPTH; i++) m_bht[m][i] = WNT;
         m_pend_v[m] = 1'b0; m_pend_pc[m] = '0; m_pend_fl[m] = 1'b0;
         m_br[m] = '0; m_mp[m] = '0;
      end
   endtask

   function automatic exp_t model_out(input int m, input stim_t s);
      exp_t        e = '0;
      logic        ex_br, ex_redir;
      logic [31:0] tgt;
      logic [3:0]  ridx = s.id_pc[5:2];
      e.pred   = (m == 1) && s.id_valid && s.id_br && m_bht[m][ridx][1];
      e.br     = m_br[m];
      e.mp     = m_mp[m];
      ex_br    = s.ex_valid && (s.op == 2'b01);
      ex_redir = (ex_br && (s.alu_f != s.ex_pred)) || (s.ex_valid && s.op[1]);
      tgt      = (ex_br && !s.alu_f) ? s.ex_pc + 32'd4 : s.ex_tgt;
      if (m_pend_v[m]) begin
         e.sel = 1'b1; e.rpc = m_pend_pc[m]; e.ifid = 1'b1; e.idex = m_pend_fl[m];
      end else if (ex_redir) begin
         e.sel = 1'b1; e.rpc = tgt; e.ifid = 1'b1; e.idex = 1'b1;
      end else if (e.pred) begin
         e.sel = 1'b1; e.rpc = s.id_tgt; e.ifid = 1'b1; e.idex = 1'b0;
      end
      return e;
   endfunction

   task automatic model_step(input int m, input stim_t s, input exp_t e);
      logic [3:0] widx = s.ex_pc[5:2];
      if (m_pend_v[m]) begin
         if (!s.stall) m_pend_v[m] = 1'b0;
      end else begin
         if (s.ex_valid && s.op == 2'b01) begin
            if (s.alu_f && m_bht[m][widx] != 2'd3) m_bht[m][widx] = m_bht[m][widx] + 2'd1;
            else if (!s.alu_f && m_bht[m][widx] != 2'd0) m_bht[m][widx] = m_bht[m][widx] - 2'd1;
            m_br[m] = m_br[m] + 32'd1;
            if (s.alu_f != s.ex_pred) m_mp[m] = m_mp[m] + 32'd1;
         end
         if (e.sel && s.stall) begin
            m_pend_v[m] = 1'b1; m_pend_pc[m] = e.rpc; m_pend_fl[m] = e.idex;
         end
      end
   endtask

   // Called just after a rising edge; returns just after the next one.
   task automatic cycle(input string name, input stim_t s);
      exp_t e, o;
      drive(s);
      for (int m = 0; m < 2; m++) sb_q.push_back(model_out(m, s));
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s/m%0d: scoreboard empty", name, m);
         end else begin
            e = sb_q.pop_front();
            o = observe(m);
            check($sformatf("%s/m%0d/pred", name, m), 32'(o.pred), 32'(e.pred));
            check($sformatf("%s/m%0d/pc_sel", name, m), 32'(o.sel), 32'(e.sel));
            check($sformatf("%s/m%0d/flush_if_id", name, m), 32'(o.ifid), 32'(e.ifid));
            check($sformatf("%s/m%0d/flush_id_ex", name, m), 32'(o.idex), 32'(e.idex));
            check($sformatf("%s/m%0d/branch_cnt", name, m), o.br, e.br);
            check($sformatf("%s/m%0d/mispred_cnt", name, m), o.mp, e.mp);
            if (e.sel) check($sformatf("%s/m%0d/redirect_pc", name, m), o.rpc, e.rpc);
            model_step(m, s, e);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic check_reset(input string name);
      exp_t o;
      for (int m = 0; m < 2; m++) begin
         o = observe(m);
         check($sformatf("%s/m%0d/pc_sel", name, m), 32'(o.sel), 32'd0);
         check($sformatf("%s/m%0d/redirect_pc", name, m), o.rpc, 32'd0);
         check($sformatf("%s/m%0d/flush_if_id", name, m), 32'(o.ifid), 32'd0);
         check($sformatf("%s/m%0d/flush_id_ex", name, m), 32'(o.idex), 32'd0);
         check($sformatf("%s/m%0d/pred", name, m), 32'(o.pred), 32'd0);
         check($sformatf("%s/m%0d/branch_cnt", name, m), o.br, 32'd0);
         check($sformatf("%s/m%0d/mispred_cnt", name, m), o.mp, 32'd0);
      end
   endtask

   initial begin
      stim_t s;
      rst_n = 1'b1;
      drive('0);
      #2 rst_n = 1'b0;
      #2 check_reset("reset");
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // EX resolution; entry 0 trains 1->2->1->2->3->3
      cycle("br_taken",     ex_stim(2'b01, 1'b1, 1'b0, 32'h40, 32'h100));
      cycle("br_not_taken", ex_stim(2'b01, 1'b0, 1'b0, 32'h40, 32'h100));
      for (int i = 0; i < 3; i++) cycle("train_taken", ex_stim(2'b01, 1'b1, 1'b1, 32'h40, 32'h100));
      cycle("id_predict",   with_id('0, 32'h40, 32'h300));
      cycle("id_alias",     with_id('0, 32'h0, 32'h340));
      cycle("ex_over_id",   with_id(ex_stim(2'b01, 1'b0, 1'b1, 32'h80, 32'h1000), 32'h40, 32'h300));

      // JALR under a three-cycle stall; later EX/ID activity must be ignored
      s = ex_stim(2'b11, 1'b0, 1'b0, 32'h60, 32'h200); s.stall = 1'b1;
      cycle("jalr_stall", s);
      s = with_id(ex_stim(2'b01, 1'b1, 1'b0, 32'h44, 32'h900), 32'h40, 32'h300); s.stall = 1'b1;
      cycle("hold1", s);
      cycle("hold2", s);
      s.stall = 1'b0;
      cycle("hold3", s);
      cycle("hold_done", '0);

      // Low saturation at entry 2, then climb back
      for (int i = 0; i < 6; i++) cycle("sat_nt", ex_stim(2'b01, 1'b0, 1'b0, 32'h8, 32'h0));
      cycle("sat_up1", with_id(ex_stim(2'b01, 1'b1, 1'b0, 32'h8, 32'h700), 32'h8, 32'h780));
      cycle("sat_up2", with_id(ex_stim(2'b01, 1'b1, 1'b0, 32'h8, 32'h700), 32'h8, 32'h780));
      cycle("sat_read", with_id('0, 32'h8, 32'h780));

      // ID-stage redirect held across a stall, then JAL
      s = with_id('0, 32'h40, 32'h300); s.stall = 1'b1;
      cycle("id_stall", s);
      s = '0; s.stall = 1'b1;
      cycle("id_hold", s);
      cycle("id_release", '0);
      cycle("idle", '0);
      cycle("jal", ex_stim(2'b10, 1'b0, 1'b0, 32'h20, 32'h500));

      // Reset while a redirect is pending
      s = ex_stim(2'b10, 1'b0, 1'b0, 32'h24, 32'h600); s.stall = 1'b1;
      cycle("jal_stall", s);
      s = with_id('0, 32'h40, 32'h300); s.stall = 1'b1;
      drive(s);
      #2 rst_n = 1'b0;
      #1 check_reset("mid_reset");
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      cycle("post_reset_id", s);
      cycle("post_reset_br", ex_stim(2'b01, 1'b1, 1'b0, 32'h40, 32'h140));
      cycle("post_reset_idle", '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_flush_ctrl.md
Name: branch_flush_ctrl

Overview:
- Parametrised successor to the pipeline flush/pc-select logic. Resolves branches, JAL and JALR in EX, and optionally predicts conditional branches in ID from a bimodal history table.
- Drives the next-PC select, the redirect target and per-stage flush strobes.
- Holds a redirect pending across fetch stalls.
- Keeps branch and mispredict statistics counters.
- Sits between the ID/EX stage logic and the PC/NPC unit.

Parameters:
- PC_W, 32, PC and target width.
- BHT_DEPTH, 16, number of 2-bit counters; must be a power of 2, at least 2.
- PREDICT, 1, prediction mode: 0 = static not-taken (all redirects from EX); 1 = bimodal BHT with ID-stage redirect.
- CNT_INIT, 2'b01, reset value of every BHT counter (weakly not-taken).
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_stall  in  1  fetch cannot accept a new PC this cycle
- id_valid  in  1  ID holds a valid instruction
- id_is_branch  in  1  ID instruction is a conditional branch
- id_pc  in  PC_W  ID instruction PC
- id_target  in  PC_W  ID branch target (pc+imm)
- id_pred_taken  out  1  prediction for the ID branch; travels down the pipe with the instruction
- ex_valid  in  1  EX holds a valid instruction
- ex_npc_op  in  2  00 seq, 01 cond branch, 10 JAL, 11 JALR
- ex_alu_f  in  1  branch condition true
- ex_pred_taken  in  1  prediction made for this instruction in ID
- ex_pc  in  PC_W  EX instruction PC
- ex_target  in  PC_W  resolved jump/branch target
- pc_sel  out  1  1 = fetch from redirect_pc
- redirect_pc  out  PC_W  next fetch address when pc_sel=1
- flush_if_id  out  1  squash the IF/ID register
- flush_id_ex  out  1  squash the ID/EX register
- branch_cnt  out  STAT_W  resolved conditional branches
- mispred_cnt  out  STAT_W  conditional-branch mispredicts

Behaviour:

BHT
- IDX_W = log2(BHT_DEPTH); index = pc[IDX_W+1:2].
- id_pred_taken = PREDICT & id_valid & id_is_branch & bht[idx(id_pc)][1]. Combinational.
- Update on a clock edge when ex_valid & ex_npc_op==01 & no pending redirect. If ex_alu_f, the counter increments and saturates at 3; otherwise it decrements and saturates at 0.
- Same-cycle read and write of one entry: the read returns the old value.
- PREDICT=0: the table is not instantiated and id_pred_taken is tied to 0.

EX resolution (combinational, ex_valid=1)
- npc_op 01: ex_alu_f != ex_pred_taken is a mispredict. Target is ex_target if ex_alu_f=1, else ex_pc+4.
- npc_op 10 or 11: always redirect, target ex_target.
- npc_op 00: no action.
- An EX redirect asserts pc_sel, flush_if_id and flush_id_ex.

ID redirect
- id_pred_taken=1 with no EX redirect asserts pc_sel with redirect_pc=id_target, plus flush_if_id only.
- An EX redirect has priority and suppresses the ID redirect in the same cycle.

Stall hold
- If a redirect occurs while pc_stall=1, latch pend_pc and pend_flush_idex and set pend_valid on the next edge.
- While pend_valid=1: outputs come from the pending registers (pc_sel=1, flush_if_id=1, flush_id_ex=pend_flush_idex). EX and ID inputs are ignored, and BHT and statistics updates are blocked.
- pend_valid clears on the first edge with pc_stall=0.
- Redirect with pc_stall=0: outputs are combinational only and no state is latched.

Statistics
- branch_cnt increments on each BHT update.
- mispred_cnt increments on each branch mispredict.
- Both wrap modulo 2^STAT_W.

Reset (rst_n=0, asynchronous)
- pend_valid=0, both counters=0, all BHT entries=CNT_INIT.
- pc_sel, flush_if_id, flush_id_ex, id_pred_taken forced to 0 and redirect_pc to 0 while rst_n=0.
- Reset mid-stall discards the pending redirect.

Decomposition:
- Shared package bpu_pkg:
  - npc_op encodings NPC_SEQ, NPC_BR, NPC_JAL, NPC_JALR;
  - 2-bit counter constants SNT, WNT, WT, ST;
  - saturating-update function.
- One sub-module, bht_2bit: a counter array with one combinational read port and one synchronous write port, async reset to CNT_INIT.

Test Plan:
- PREDICT=0, ex_npc_op=01, alu_f=1, ex_target=0x100 -> pc_sel=1, redirect_pc=0x100, both flushes 1, mispred_cnt=1. With alu_f=0 -> no flush, branch_cnt increments.
- PREDICT=1, three taken resolves at pc 0x40 -> entry 0 reaches 3. Next id_pc=0x40, id_is_branch=1 -> id_pred_taken=1, redirect_pc=id_target, flush_if_id=1, flush_id_ex=0.
- ex_pred_taken=1, alu_f=0, ex_pc=0x80 -> redirect_pc=0x84, both flushes, mispred_cnt+1. Simultaneously id_pred_taken=1 -> ID redirect suppressed.
- JALR (11) to 0x200 with pc_stall=1 for 3 cycles -> pc_sel/flushes held 4 cycles, redirect_pc=0x200 throughout, cleared after the stall drops, no counter change during the hold.
- Counter saturation: 5 not-taken at one index -> counter 0, not below. BHT_DEPTH=16: pcs 0x0 and 0x40 alias to the same entry.
- Assert rst_n low mid-pending -> pc_sel=0 immediately, counters 0, BHT entries read CNT_INIT.
